neuron_feeder: RTL
==================

NEURON_FEEDER -- requirements
Module: neuron_feeder

Interface
REQ-001 Parameter N_INPUTS, 16, number of value/weight pairs per neuron; legal range 1..256.
REQ-002 Parameter AW, 8, address width of value and weight memories; 2**AW SHALL be >= N_INPUTS.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request one neuron evaluation; sampled only in IDLE.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 val_addr  output  AW  read address to value memory (1-cycle synchronous read).
REQ-008 wgt_addr  output  AW  read address to weight memory (1-cycle synchronous read).
REQ-009 val_rdata  input  16  signed Q8.8 value, valid one cycle after val_addr.
REQ-010 wgt_rdata  input  16  signed Q8.8 weight, valid one cycle after wgt_addr.
REQ-011 mac_value  output  16  signed operand to downstream MAC; 0 outside FEED.
REQ-012 mac_weight  output  16  signed operand to downstream MAC; 0 outside FEED.
REQ-013 mac_clr_n  output  1  active-low synchronous clear to MAC (clears product and sum registers).
REQ-014 mac_out  input  16  MAC result, sum[23:8] of the 33-bit signed accumulator, Q8.8.
REQ-015 result  output  16  captured neuron output, Q8.8 signed.
REQ-016 result_valid  output  1  result held stable while high.
REQ-017 result_ready  input  1  consumer acceptance; transfer when result_valid && result_ready.

Function
REQ-018 FSM states SHALL be IDLE, CLEAR, FEED, DRAIN, DONE.
REQ-019 IDLE -> CLEAR when start=1; start in any other state SHALL be ignored (no queuing).
REQ-020 CLEAR lasts exactly 1 cycle: mac_clr_n=0, val_addr=wgt_addr=0, count<=0; then FEED.
REQ-021 FEED lasts exactly N_INPUTS cycles; in FEED cycle k (0-based) mac_value=val_rdata, mac_weight=wgt_rdata (data of address k) and addresses = k+1 (don't-care value on last cycle).
REQ-022 DRAIN lasts exactly 2 cycles with operands 0, covering MAC product and sum register stages.
REQ-023 At the end of the 2nd DRAIN cycle result SHALL register mac_out; state -> DONE; result_valid=1 from the next cycle.
REQ-024 Start-to-result_valid latency SHALL be N_INPUTS+4 cycles (start sampled cycle = 0).
REQ-025 DONE -> IDLE on the cycle result_valid && result_ready; result_valid deasserts the following cycle; result retains its value until next capture.
REQ-026 result_ready and start both high in DONE: handshake completes, start ignored; a new start is accepted only once IDLE is reached.
REQ-027 mac_clr_n SHALL be 1 in FEED, DRAIN, DONE, IDLE; operands SHALL be 0 in all states except FEED so idle MAC accumulates nothing.
REQ-028 count SHALL be ceil(log2(N_INPUTS+1)) bits wide and never wrap; N_INPUTS=1 gives one FEED cycle.

Reset
REQ-029 While reset=1 (asynchronously): state=IDLE, count=0, addresses=0, result=0, result_valid=0, busy=0, mac_clr_n=0 (holds MAC cleared), operands=0.
REQ-030 Reset asserted mid-evaluation SHALL abandon it; no result_valid pulse for the aborted evaluation.

Configuration
REQ-031 Macro NEURON_RELU_EN defined: captured result = 0x0000 when mac_out[15]=1, else mac_out; undefined: result = mac_out unmodified; latency identical both ways.

Verification
REQ-032 N=4, values 0x0100, weights 0x0080, start pulse -> result_valid at cycle 8, result=0x0200.
REQ-033 N=4, values 0x0100, weights 0xFF00 -> result=0xFC00 without NEURON_RELU_EN, 0x0000 with it.
REQ-034 N=1, value 0x0300, weight 0x0200, result_ready held 0 for 5 cycles -> result=0x0600 stable, result_valid held, then IDLE after ready.
REQ-035 Reset asserted in FEED cycle 2 of N=16 -> busy=0, mac_clr_n=0 immediately; next run returns correct sum with no stale accumulation.
REQ-036 start held high across busy period and DONE with result_ready=1 -> exactly one evaluation per IDLE visit, back-to-back results identical.

Source files
------------

// File: rtl/neuron_feeder.sv
// Sequences one neuron evaluation: streams value/weight pairs into an external MAC, drains its pipeline and captures the sum.
// Optional macro NEURON_RELU_EN clamps negative captured results to zero.
module neuron_feeder #(
  parameter int N_INPUTS = 16,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic [AW-1:0] val_addr,
  output logic [AW-1:0] wgt_addr,
  input  logic [15:0]   val_rdata,
  input  logic [15:0]   wgt_rdata,
  output logic [15:0]   mac_value,
  output logic [15:0]   mac_weight,
  output logic          mac_clr_n,
  input  logic [15:0]   mac_out,
  output logic [15:0]   result,
  output logic          result_valid,
  input  logic          result_ready,
  output logic [2:0]    dbg_state
);

  localparam int CW = $clog2(N_INPUTS + 1);
  localparam logic [CW-1:0] LAST_FEED  = CW'(N_INPUTS - 1);
  localparam logic [CW-1:0] LAST_DRAIN = CW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Result handshake: result is offered while result_valid is high and stays
  // unchanged until the cycle where result_valid && result_ready transfers it.

  state_t        state, state_next;
  logic [CW-1:0] count, count_next;
  logic [CW:0]   count_inc;
  logic          capture;
  logic [15:0]   result_d;
  logic          clr_n_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      result  <= '0;
      clr_n_q <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      clr_n_q <= (state_next != CLEAR);
      if (capture) result <= result_d;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = CLEAR;
      end
      CLEAR: begin
        count_next = '0;
        state_next = FEED;
      end
      FEED: begin
        if (count == LAST_FEED) begin
          count_next = '0;
          state_next = DRAIN;
        end else begin
          count_next = count + 1'b1;
        end
      end
      DRAIN: begin
        // Two drain cycles cover the MAC product and sum register stages.
        if (count == LAST_DRAIN) begin
          count_next = '0;
          capture    = 1'b1;
          state_next = DONE;
        end else begin
          count_next = count + 1'b1;
        end
      end
      DONE: begin
        if (result_ready) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

`ifdef NEURON_RELU_EN
  assign result_d = mac_out[15] ? 16'h0000 : mac_out;
`else
  assign result_d = mac_out;
`endif

  // Memories read one cycle behind the address, so FEED cycle k already points at k+1.
  assign count_inc = {1'b0, count} + {{CW{1'b0}}, 1'b1};

  always_comb begin
    val_addr   = '0;
    wgt_addr   = '0;
    mac_value  = '0;
    mac_weight = '0;
    if (state == FEED) begin
      val_addr   = AW'(count_inc);
      wgt_addr   = AW'(count_inc);
      mac_value  = val_rdata;
      mac_weight = wgt_rdata;
    end
  end

  assign busy         = (state != IDLE);
  assign mac_clr_n    = clr_n_q;
  assign result_valid = (state == DONE);
  assign dbg_state    = state;

endmodule
